reset_domain_sequencer: RTL and testbench
=========================================

Name: reset_domain_sequencer

Overview:
- Control-clock FSM that sequences reset release for up to N downstream clock domains.
- Waits for PLL/MMCM lock, holds all domains in reset for a programmable time, then releases domains one at a time in increasing index order.
- Before releasing the next domain, it waits for the current domain's synchronized-deassert acknowledge.
- Re-asserts everything on lock loss or software reset; flags acknowledge timeouts.

Parameters:
- N_DOMAINS, 4, number of sequenced domains (1..8).
- HOLD_CYCLES, 256, clock cycles all resets are held after lock before the first release (>=1).
- ACK_TIMEOUT, 4096, clock cycles allowed per domain for its acknowledge before error (>=2).
- SYNC_STAGES, 2, flip-flop stages on every asynchronous input (>=2).

Ports:
- clock, input, 1, control clock; free-running, independent of the PLL.
- areset, input, 1, asynchronous active-high reset.
- pll_locked, input, 1, asynchronous lock indication; synchronized internally.
- sw_reset_req, input, 1, synchronous single-cycle request to restart the sequence.
- domain_ack, input, N_DOMAINS, asynchronous; bit i high means domain i's local synchronizer has deasserted reset.
- domain_reset, output, N_DOMAINS, active-high reset request per domain; consumed by per-domain synchronizers.
- all_ready, output, 1, high only in RUN.
- seq_state, output, 3, current FSM state encoding.
- err_timeout, output, 1, sticky acknowledge-timeout flag; cleared by areset or sw_reset_req.
- err_domain, output, 3, index of the domain that timed out; valid while err_timeout is high.

Behaviour:
- Reset is areset (asynchronous, active-high); clock is clock.
- While areset is high:
  - state = ASSERT, domain_reset = all ones, all_ready = 0.
  - err_timeout = 0, err_domain = 0, counters = 0, synchronizer flops = 0.
- pll_locked and domain_ack each pass through SYNC_STAGES flops. Latency from input to FSM is SYNC_STAGES cycles.
- States (encoding): ASSERT=0, WAIT_LOCK=1, HOLD=2, RELEASE=3, WAIT_ACK=4, RUN=5, ERROR=6.
- ASSERT: domain_reset = all ones, idx = 0. Go to WAIT_LOCK the next cycle.
- WAIT_LOCK: stay while lock_s = 0. When lock_s = 1, clear the counter and go to HOLD.
- HOLD: count up. When count == HOLD_CYCLES-1, go to RELEASE. Duration is exactly HOLD_CYCLES cycles.
- RELEASE: clear domain_reset[idx] (single cycle), clear the counter, go to WAIT_ACK. Bits below idx stay 0; bits above idx stay 1.
- WAIT_ACK: count up.
  - If ack_s[idx] = 1:
    - If idx == N_DOMAINS-1, go to RUN.
    - Otherwise, idx++ and go to RELEASE.
  - Else if count == ACK_TIMEOUT-1: set err_timeout, latch err_domain = idx, go to ERROR.
  - Ack takes precedence over timeout in the same cycle.
- RUN: all_ready = 1, domain_reset = 0.
- ERROR: domain_reset = all ones, wait for lock_s = 1 and all ack_s = 0, then go to ASSERT. No automatic clear of err_timeout.
- Lock loss: lock_s = 0 in HOLD, RELEASE, WAIT_ACK or RUN → set domain_reset = all ones in the same cycle, then go to WAIT_LOCK. It does not go to ERROR.
- sw_reset_req in any state other than ASSERT:
  - Clears err_timeout and goes to ASSERT.
  - Has priority over lock loss and ack.
  - Ignored in ASSERT.
- domain_reset is registered (glitch-free); assertion is never delayed by more than 1 cycle after the triggering event is seen.
- Counters are sized to clog2(max(HOLD_CYCLES, ACK_TIMEOUT)) bits and never wrap. Counting saturates by state exit.

Optional Feature:
- Macro: RESET_SEQ_LOCK_FILTER_EN.
- Defined: lock_s must be 1 for 16 consecutive cycles before leaving WAIT_LOCK (5-bit filter counter). A single 0 restarts the count. Lock-loss detection remains immediate.
- Undefined: the first cycle with lock_s = 1 leaves WAIT_LOCK, as described in Behaviour.

Decomposition:
- Package reset_seq_pkg holds:
  - state enum seq_state_e (3-bit, encodings above);
  - constant LOCK_FILTER_LEN = 16;
  - function for counter width.
- Sub-module reset_seq_sync: parameterized-width multi-stage synchronizer with asynchronous clear. Used for pll_locked and domain_ack.

Test Plan:
- Power-up: areset 10 cycles, lock at cycle 20, acks return 3 cycles after each release → bit 0 releases HOLD_CYCLES cycles after lock_s rises; bits release in order 0,1,2,3; all_ready after the 4th ack; err_timeout = 0.
- Lock loss in RUN: drop pll_locked → domain_reset = 4'b1111 within SYNC_STAGES+1 cycles, seq_state = 1; restore lock → full sequence repeats.
- Timeout: domain 2 ack never arrives → at ACK_TIMEOUT cycles err_timeout = 1, err_domain = 2, domain_reset = 4'b1111, seq_state = 6.
- sw_reset_req in WAIT_ACK at idx 1 with err_timeout previously set → next state ASSERT, err_timeout = 0, domain_reset = 4'b1111.
- Simultaneous events: ack and timeout in the same cycle → ack wins, no error. sw_reset_req and lock drop in the same cycle → ASSERT.
- areset mid-HOLD → immediate asynchronous all-ones reset, state 0, counters cleared. With RESET_SEQ_LOCK_FILTER_EN, a lock pulse of 10 cycles does not leave WAIT_LOCK.

Source files
------------

// File: rtl/reset_seq_pkg.sv
// Shared types and helpers for the reset domain sequencer.
// State encoding, lock filter length and counter sizing.
package reset_seq_pkg;

  typedef enum logic [2:0] {
    ST_ASSERT    = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_HOLD      = 3'd2,
    ST_RELEASE   = 3'd3,
    ST_WAIT_ACK  = 3'd4,
    ST_RUN       = 3'd5,
    ST_ERROR     = 3'd6
  } seq_state_e;

  localparam int LOCK_FILTER_LEN = 16;

  function automatic int cnt_width(input int a, input int b);
    int m;
    int w;
    m = (a > b) ? a : b;
    w = 1;
    while ((1 << w) < m) w++;
    return w;
  endfunction

endpackage

// File: rtl/reset_seq_sync.sv
// Multi-stage synchronizer with asynchronous clear.
// Brings pll_locked and domain_ack into the control clock domain.
module reset_seq_sync #(
  parameter int WIDTH  = 1,
  parameter int STAGES = 2
) (
  input  logic             clock,
  input  logic             areset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [STAGES-1:0][WIDTH-1:0] ff;

  // shift the input through the flop chain, cleared on areset
  always_ff @(posedge clock or posedge areset) begin
    if (areset) ff <= '0;
    else        ff <= {ff[STAGES-2:0], d};
  end

  assign q = ff[STAGES-1];

endmodule

// File: rtl/reset_domain_sequencer.sv
// Sequences reset release across clock domains after PLL lock.
// Optional lock filter: define RESET_SEQ_LOCK_FILTER_EN.
module reset_domain_sequencer
  import reset_seq_pkg::*;
#(
  parameter int N_DOMAINS   = 4,
  parameter int HOLD_CYCLES = 256,
  parameter int ACK_TIMEOUT = 4096,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clock,
  input  logic                 areset,
  input  logic                 pll_locked,
  input  logic                 sw_reset_req,
  input  logic [N_DOMAINS-1:0] domain_ack,
  output logic [N_DOMAINS-1:0] domain_reset,
  output logic                 all_ready,
  output logic [2:0]           seq_state,
  output logic                 err_timeout,
  output logic [2:0]           err_domain
);

  localparam int CW = cnt_width(HOLD_CYCLES, ACK_TIMEOUT);
  localparam int IW = (N_DOMAINS > 1) ? $clog2(N_DOMAINS) : 1;

  localparam logic [N_DOMAINS-1:0] ALL_ONES = '1;
  localparam logic [N_DOMAINS-1:0] ONE = N_DOMAINS'(1);
  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] ACK_LAST  = CW'(ACK_TIMEOUT - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(N_DOMAINS - 1);

  seq_state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [N_DOMAINS-1:0] dr_q, dr_d;
  logic err_q, err_d;
  logic [2:0] errd_q, errd_d;

  logic lock_s;
  logic [N_DOMAINS-1:0] ack_s;
  logic ack_cur;
  logic lock_go;

  reset_seq_sync #(
    .WIDTH (1),
    .STAGES(SYNC_STAGES)
  ) u_lock_sync (
    .clock (clock),
    .areset(areset),
    .d     (pll_locked),
    .q     (lock_s)
  );

  reset_seq_sync #(
    .WIDTH (N_DOMAINS),
    .STAGES(SYNC_STAGES)
  ) u_ack_sync (
    .clock (clock),
    .areset(areset),
    .d     (domain_ack),
    .q     (ack_s)
  );

  assign ack_cur = ack_s[idx_q];

`ifdef RESET_SEQ_LOCK_FILTER_EN
  logic [4:0] filt_q, filt_d;
  assign lock_go = lock_s && (filt_q == 5'(LOCK_FILTER_LEN - 1));
`else
  assign lock_go = lock_s;
`endif

  // state, counters and registered reset outputs
  always_ff @(posedge clock or posedge areset) begin
    if (areset) begin
      state_q <= ST_ASSERT;
      cnt_q   <= '0;
      idx_q   <= '0;
      dr_q    <= ALL_ONES;
      err_q   <= 1'b0;
      errd_q  <= '0;
`ifdef RESET_SEQ_LOCK_FILTER_EN
      filt_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      dr_q    <= dr_d;
      err_q   <= err_d;
      errd_q  <= errd_d;
`ifdef RESET_SEQ_LOCK_FILTER_EN
      filt_q  <= filt_d;
`endif
    end
  end

  // next-state, counter and reset-mask decisions
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    dr_d    = dr_q;
    err_d   = err_q;
    errd_d  = errd_q;
`ifdef RESET_SEQ_LOCK_FILTER_EN
    filt_d  = '0;
`endif
    if (state_q != ST_ASSERT && sw_reset_req) begin
      state_d = ST_ASSERT;
      err_d   = 1'b0;
      dr_d    = ALL_ONES;
    end else begin
      unique case (state_q)
        ST_ASSERT: begin
          state_d = ST_WAIT_LOCK;
          dr_d    = ALL_ONES;
          idx_d   = '0;
          cnt_d   = '0;
        end
        ST_WAIT_LOCK: begin
          dr_d  = ALL_ONES;
          idx_d = '0;
          cnt_d = '0;
`ifdef RESET_SEQ_LOCK_FILTER_EN
          if (lock_s && !lock_go) filt_d = filt_q + 5'd1;
`endif
          if (lock_go) state_d = ST_HOLD;
        end
        ST_HOLD: begin
          if (!lock_s) begin
            state_d = ST_WAIT_LOCK;
            dr_d    = ALL_ONES;
          end else if (cnt_q == HOLD_LAST) begin
            state_d = ST_RELEASE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        ST_RELEASE: begin
          if (!lock_s) begin
            state_d = ST_WAIT_LOCK;
            dr_d    = ALL_ONES;
          end else begin
            dr_d    = dr_q & ~(ONE << idx_q);
            cnt_d   = '0;
            state_d = ST_WAIT_ACK;
          end
        end
        ST_WAIT_ACK: begin
          if (!lock_s) begin
            state_d = ST_WAIT_LOCK;
            dr_d    = ALL_ONES;
          end else if (ack_cur) begin
            if (idx_q == IDX_LAST) begin
              state_d = ST_RUN;
              dr_d    = '0;
            end else begin
              idx_d   = idx_q + 1'b1;
              state_d = ST_RELEASE;
            end
          end else if (cnt_q == ACK_LAST) begin
            state_d = ST_ERROR;
            err_d   = 1'b1;
            errd_d  = 3'(idx_q);
            dr_d    = ALL_ONES;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        ST_RUN: begin
          if (!lock_s) begin
            state_d = ST_WAIT_LOCK;
            dr_d    = ALL_ONES;
          end else begin
            dr_d = '0;
          end
        end
        ST_ERROR: begin
          dr_d = ALL_ONES;
          if (lock_s && ack_s == '0) state_d = ST_ASSERT;
        end
        default: begin
          state_d = ST_ASSERT;
          dr_d    = ALL_ONES;
        end
      endcase
    end
  end

  assign domain_reset = dr_q;
  assign all_ready    = (state_q == ST_RUN);
  assign seq_state    = state_q;
  assign err_timeout  = err_q;
  assign err_domain   = errd_q;

endmodule

// File: tb/tb_reset_domain_sequencer.sv
// Testbench for reset_domain_sequencer: behavioural model plus
// directed scenarios with literal expectations.
module tb_reset_domain_sequencer;

  localparam int N = 4;
  localparam int H = 16;
  localparam int A = 32;
  localparam int S = 2;
`ifdef RESET_SEQ_LOCK_FILTER_EN
  localparam int FILT = 15;
`else
  localparam int FILT = 0;
`endif
  localparam logic [3:0] F = 4'hF;

  logic clock = 1'b0;
  logic areset = 1'b1;
  logic pll_locked = 1'b0;
  logic sw_reset_req = 1'b0;
  logic [3:0] domain_ack = '0;
  logic [3:0] domain_reset;
  logic all_ready;
  logic [2:0] seq_state;
  logic err_timeout;
  logic [2:0] err_domain;

  reset_domain_sequencer #(
    .N_DOMAINS  (N),
    .HOLD_CYCLES(H),
    .ACK_TIMEOUT(A),
    .SYNC_STAGES(S)
  ) dut (
    .clock       (clock),
    .areset      (areset),
    .pll_locked  (pll_locked),
    .sw_reset_req(sw_reset_req),
    .domain_ack  (domain_ack),
    .domain_reset(domain_reset),
    .all_ready   (all_ready),
    .seq_state   (seq_state),
    .err_timeout (err_timeout),
    .err_domain  (err_domain)
  );

  always #5 clock = ~clock;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int m_st, m_cnt, m_idx, m_filt, m_errd;
  logic [3:0] m_dr;
  bit m_err;
  logic lk_h [S];
  logic [3:0] ak_h [S];

  task automatic model_reset();
    m_st = 0; m_cnt = 0; m_idx = 0; m_filt = 0; m_errd = 0;
    m_dr = F; m_err = 0;
    for (int k = 0; k < S; k++) begin
      lk_h[k] = 1'b0;
      ak_h[k] = '0;
    end
  endtask

  task automatic model_step();
    logic ls;
    logic [3:0] as;
    ls = lk_h[S-1];
    as = ak_h[S-1];
    for (int k = S - 1; k > 0; k--) begin
      lk_h[k] = lk_h[k-1];
      ak_h[k] = ak_h[k-1];
    end
    lk_h[0] = pll_locked;
    ak_h[0] = domain_ack;
    if (m_st != 1) m_filt = 0;
    if (m_st == 0) begin
      m_st = 1; m_dr = F; m_idx = 0; m_cnt = 0;
    end else if (sw_reset_req) begin
      m_st = 0; m_err = 0; m_dr = F;
    end else if (!ls && m_st >= 2 && m_st <= 5) begin
      m_st = 1; m_dr = F;
    end else begin
      case (m_st)
        1: begin
          m_idx = 0; m_dr = F;
          if (ls && m_filt == FILT) begin
            m_st = 2; m_cnt = 0;
          end else if (ls) m_filt++;
          else m_filt = 0;
        end
        2: if (m_cnt == H - 1) m_st = 3; else m_cnt++;
        3: begin
          m_dr = F << (m_idx + 1);
          m_cnt = 0; m_st = 4;
        end
        4: begin
          if (as[m_idx]) begin
            if (m_idx == N - 1) begin
              m_st = 5; m_dr = '0;
            end else begin
              m_idx++; m_st = 3;
            end
          end else if (m_cnt == A - 1) begin
            m_err = 1; m_errd = m_idx; m_dr = F; m_st = 6;
          end else m_cnt++;
        end
        5: m_dr = '0;
        6: begin
          m_dr = F;
          if (ls && as == '0) m_st = 0;
        end
        default: m_st = 0;
      endcase
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clock or posedge areset);
      if (areset) model_reset();
      else model_step();
    end
  end

  // compare every cycle on the falling edge
  initial forever begin
    @(negedge clock);
    chk("state", int'(seq_state), m_st);
    chk("dreset", int'(domain_reset), int'(m_dr));
    chk("ready", int'(all_ready), int'(m_st == 5));
    chk("err", int'(err_timeout), int'(m_err));
    if (m_err || areset) chk("errdom", int'(err_domain), m_errd);
  end

  // ---------------- domain acknowledge responder ----------------
  int dly [4] = '{3, 3, 3, 3};
  int lowc [4] = '{0, 0, 0, 0};

  initial forever begin
    @(posedge clock);
    #1;
    for (int i = 0; i < 4; i++) begin
      if (domain_reset[i]) lowc[i] = 0;
      else if (lowc[i] < 100000) lowc[i]++;
      domain_ack[i] = (lowc[i] >= dly[i]);
    end
  end

  // ---------------- directed scenarios ----------------
  task automatic wait_state(input int s, input int budget, input string nm);
    int c;
    c = 0;
    while (int'(seq_state) != s && c < budget) begin
      @(negedge clock);
      c++;
    end
    chk(nm, int'(seq_state), s);
  endtask

  task automatic sw_pulse();
    @(posedge clock); #1;
    sw_reset_req = 1'b1;
    @(posedge clock); #1;
    sw_reset_req = 1'b0;
  endtask

  initial begin
    int c;
    repeat (10) @(posedge clock);
    @(negedge clock);
    chk("rst_state", int'(seq_state), 0);
    chk("rst_dreset", int'(domain_reset), 15);
    chk("rst_ready", int'(all_ready), 0);
    chk("rst_err", int'(err_timeout), 0);
    @(posedge clock); #1;
    areset = 1'b0;
    repeat (9) @(posedge clock);
    #1;
    pll_locked = 1'b1;
    c = 0;
    while (domain_reset[0] && c < 300) begin
      @(negedge clock);
      c++;
    end
    chk("rel0_latency", c, H + 5 + FILT);
    chk("rel0_mask", int'(domain_reset), 14);
    wait_state(5, 300, "run1");
    chk("run1_dreset", int'(domain_reset), 0);
    chk("run1_ready", int'(all_ready), 1);
    chk("run1_err", int'(err_timeout), 0);

    // lock loss in RUN
    @(posedge clock); #1;
    pll_locked = 1'b0;
    repeat (4) @(negedge clock);
    chk("lockloss_dreset", int'(domain_reset), 15);
    chk("lockloss_state", int'(seq_state), 1);
    @(posedge clock); #1;
    pll_locked = 1'b1;
    wait_state(5, 300, "run2");
    chk("run2_ready", int'(all_ready), 1);

    // domain 2 never acknowledges
    dly[2] = 1000000;
    sw_pulse();
    wait_state(6, 400, "to_state");
    chk("to_err", int'(err_timeout), 1);
    chk("to_dom", int'(err_domain), 2);
    chk("to_dreset", int'(domain_reset), 15);

    // sw reset while waiting on domain 1 with error still set
    dly[2] = 3;
    dly[1] = 20;
    c = 0;
    while (!(seq_state == 3'd4 && domain_reset == 4'b1100 && err_timeout)
           && c < 400) begin
      @(negedge clock);
      c++;
    end
    chk("idx1_reached", int'(domain_reset), 12);
    sw_pulse();
    @(negedge clock);
    chk("sw_state", int'(seq_state), 0);
    chk("sw_err", int'(err_timeout), 0);
    chk("sw_dreset", int'(domain_reset), 15);

    // ack arrives on the last allowed cycle
    dly[1] = A - 2;
    wait_state(5, 400, "ackwin_run");
    chk("ackwin_err", int'(err_timeout), 0);

    // ack one cycle too late
    dly[1] = 3;
    dly[0] = A - 1;
    sw_pulse();
    wait_state(6, 400, "late_state");
    chk("late_dom", int'(err_domain), 0);
    dly[0] = 3;
    sw_pulse();
    @(negedge clock);
    chk("err_sw_state", int'(seq_state), 0);
    chk("err_sw_err", int'(err_timeout), 0);
    wait_state(5, 400, "run3");

    // sw request coinciding with lock loss
    @(posedge clock); #1;
    pll_locked = 1'b0;
    @(posedge clock);
    @(posedge clock); #1;
    sw_reset_req = 1'b1;
    @(posedge clock); #1;
    sw_reset_req = 1'b0;
    @(negedge clock);
    chk("swlock_state", int'(seq_state), 0);
    chk("swlock_dreset", int'(domain_reset), 15);
    @(posedge clock); #1;
    pll_locked = 1'b1;
    wait_state(5, 400, "run4");

    // asynchronous reset in the middle of HOLD
    sw_pulse();
    wait_state(2, 100, "hold_reached");
    repeat (3) @(negedge clock);
    #2;
    areset = 1'b1;
    #1;
    chk("ar_state", int'(seq_state), 0);
    chk("ar_dreset", int'(domain_reset), 15);
    chk("ar_ready", int'(all_ready), 0);
    chk("ar_err", int'(err_timeout), 0);
    repeat (3) @(posedge clock);
    #1;
    areset = 1'b0;
    wait_state(5, 400, "run5");

`ifdef RESET_SEQ_LOCK_FILTER_EN
    // a short lock pulse must not leave WAIT_LOCK
    pll_locked = 1'b0;
    repeat (5) @(posedge clock);
    #1;
    pll_locked = 1'b1;
    repeat (10) @(posedge clock);
    #1;
    pll_locked = 1'b0;
    repeat (20) @(posedge clock);
    @(negedge clock);
    chk("filt_state", int'(seq_state), 1);
    @(posedge clock); #1;
    pll_locked = 1'b1;
    wait_state(5, 400, "run_filt");
`endif

    repeat (3) @(posedge clock);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
